// File: rtl/spi_master_multi.sv
// SPI master, multi-slave, CPOL/CPHA per transfer; accept->rx_valid = 1+(2*WIDTH+1)*DIV cycles; tx_ready only in IDLE.
// Define SPI_MASTER_LOOPBACK_EN to feed the receive shifter from the mosi register instead of miso.
module spi_master_multi #(
    parameter int WIDTH      = 8,
    parameter int NUM_SLAVES = 4,
    parameter int DIV        = 4,
    localparam int SSW       = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    input  logic [WIDTH-1:0]      tx_data,
    input  logic [SSW-1:0]        tx_ss,
    input  logic                  cpol,
    input  logic                  cpha,
    output logic                  rx_valid,
    output logic [WIDTH-1:0]      rx_data,
    output logic                  sclk,
    output logic                  mosi,
    input  logic                  miso,
    output logic [NUM_SLAVES-1:0] ss_n
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SETUP = 2'd1;
    localparam logic [1:0] ST_XFER  = 2'd2;
    localparam logic [1:0] ST_HOLD  = 2'd3;

    localparam int CW    = $clog2(DIV);
    localparam int EW    = $clog2(2 * WIDTH + 1);
    localparam int EDGES = 2 * WIDTH;

    logic [1:0]            state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [EW-1:0]         edge_q, edge_d;
    logic                  cpol_q, cpol_d;
    logic                  cpha_q, cpha_d;
    logic [WIDTH-1:0]      tx_sh_q, tx_sh_d;
    logic [WIDTH-1:0]      rx_sh_q, rx_sh_d;
    logic [WIDTH-1:0]      rx_data_q, rx_data_d;
    logic                  rx_valid_q, rx_valid_d;
    logic                  sclk_q, sclk_d;
    logic                  mosi_q, mosi_d;
    logic [NUM_SLAVES-1:0] ss_n_q, ss_n_d;

    logic                  cnt_last;
    logic [EW-1:0]         edge_nxt;
    logic                  samp_edge;
    logic                  shift_ok;
    logic                  rx_bit;
    logic [NUM_SLAVES-1:0] sel_n;

`ifdef SPI_MASTER_LOOPBACK_EN
    assign rx_bit = mosi_q;
`else
    assign rx_bit = miso;
`endif

    assign cnt_last  = (cnt_q == CW'(DIV - 1));
    assign edge_nxt  = edge_q + 1'b1;
    // Odd edges lead; CPHA=0 samples on leading edges, CPHA=1 on trailing ones.
    assign samp_edge = edge_nxt[0] ^ cpha_q;
    // CPHA=0 already presented the MSB in SETUP, so its final trailing edge has nothing left to shift.
    assign shift_ok  = cpha_q || (edge_nxt != EW'(EDGES));

    // Out-of-range indices leave every select deasserted.
    always_comb begin
        sel_n = '1;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (tx_ss == SSW'(i)) begin
                sel_n[i] = 1'b0;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        edge_d     = edge_q;
        cpol_d     = cpol_q;
        cpha_d     = cpha_q;
        tx_sh_d    = tx_sh_q;
        rx_sh_d    = rx_sh_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        sclk_d     = sclk_q;
        mosi_d     = mosi_q;
        ss_n_d     = ss_n_q;

        case (state_q)
            ST_IDLE: begin
                if (tx_valid) begin
                    state_d = ST_SETUP;
                    cnt_d   = '0;
                    edge_d  = '0;
                    cpol_d  = cpol;
                    cpha_d  = cpha;
                    sclk_d  = cpol;
                    rx_sh_d = '0;
                    ss_n_d  = sel_n;
                    if (!cpha) begin
                        mosi_d  = tx_data[WIDTH-1];
                        tx_sh_d = {tx_data[WIDTH-2:0], 1'b0};
                    end else begin
                        tx_sh_d = tx_data;
                    end
                end
            end

            ST_SETUP, ST_XFER: begin
                cnt_d = cnt_last ? '0 : cnt_q + 1'b1;
                if (cnt_last) begin
                    sclk_d = ~sclk_q;
                    edge_d = edge_nxt;
                    if (samp_edge) begin
                        rx_sh_d = {rx_sh_q[WIDTH-2:0], rx_bit};
                    end else if (shift_ok) begin
                        mosi_d  = tx_sh_q[WIDTH-1];
                        tx_sh_d = {tx_sh_q[WIDTH-2:0], 1'b0};
                    end
                    if (state_q == ST_SETUP) begin
                        state_d = ST_XFER;
                    end else if (edge_nxt == EW'(EDGES)) begin
                        state_d = ST_HOLD;
                    end
                end
            end

            ST_HOLD: begin
                cnt_d = cnt_last ? '0 : cnt_q + 1'b1;
                if (cnt_last) begin
                    state_d    = ST_IDLE;
                    ss_n_d     = '1;
                    rx_data_d  = rx_sh_q;
                    rx_valid_d = 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
                ss_n_d  = '1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            edge_q     <= '0;
            cpol_q     <= 1'b0;
            cpha_q     <= 1'b0;
            tx_sh_q    <= '0;
            rx_sh_q    <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
            ss_n_q     <= '1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            edge_q     <= edge_d;
            cpol_q     <= cpol_d;
            cpha_q     <= cpha_d;
            tx_sh_q    <= tx_sh_d;
            rx_sh_q    <= rx_sh_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            sclk_q     <= sclk_d;
            mosi_q     <= mosi_d;
            ss_n_q     <= ss_n_d;
        end
    end

    assign tx_ready = (state_q == ST_IDLE);
    assign rx_valid = rx_valid_q;
    assign rx_data  = rx_data_q;
    assign sclk     = sclk_q;
    assign mosi     = mosi_q;
    assign ss_n     = ss_n_q;

endmodule

// File: tb/tb_spi_master_multi.sv
// Scoreboard bench for spi_master_multi: directed transfers, a behavioural SPI slave and an rx_valid monitor.
module tb_spi_master_multi;

`ifdef SPI_MASTER_LOOPBACK_EN
    localparam bit LB = 1'b1;
`else
    localparam bit LB = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] tx_data;
    logic [1:0] tx_ss;
    logic       cpol;
    logic       cpha;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       sclk;
    logic       mosi;
    logic       miso;
    logic       miso_slv = 1'b0;
    logic [3:0] ss_n;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [7:0] exp_q[$];
    int         acc_q[$];
    logic [7:0] sw_q[$];
    logic [7:0] mo_q[$];
    logic       mode_cpha = 1'b0;

    assign miso = LB ? 1'b0 : miso_slv;

    spi_master_multi #(.WIDTH(8), .NUM_SLAVES(4), .DIV(4)) dut (
        .clk(clk), .rst(rst),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data), .tx_ss(tx_ss),
        .cpol(cpol), .cpha(cpha),
        .rx_valid(rx_valid), .rx_data(rx_data),
        .sclk(sclk), .mosi(mosi), .miso(miso), .ss_n(ss_n)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] exp_rx(input logic [7:0] t, input logic [7:0] s);
        return LB ? t : s;
    endfunction

    // Monitor: every rx_valid pulse must match the oldest outstanding transfer.
    always @(negedge clk) begin
        logic [7:0] e;
        int         a;
        if (rx_valid) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL rx_unexpected: got rx_valid with rx_data %0h, expected none", rx_data);
            end else begin
                e = exp_q.pop_front();
                a = acc_q.pop_front();
                chk("rx_data", {24'd0, rx_data}, {24'd0, e});
                chk("rx_latency", cyc - a, 69);
            end
        end
    end

    // Slave: drives miso on the non-sampling edges and captures mosi on the sampling edges.
    logic [7:0] cur_w, srx, mexp;
    int         sidx, sedges;
    logic       sel_prev = 1'b0, sclk_prev = 1'b0, scph = 1'b0;
    always @(negedge clk) begin
        logic sel;
        sel = (ss_n != 4'hF);
        if (sel && !sel_prev) begin
            cur_w  = 8'h00;
            if (sw_q.size() > 0) cur_w = sw_q.pop_front();
            scph   = mode_cpha;
            sedges = 0;
            srx    = 8'h00;
            sidx   = 7;
            if (!scph) begin
                miso_slv = cur_w[sidx];
                sidx     = 6;
            end
        end else if (sel && (sclk != sclk_prev)) begin
            sedges++;
            if ((sedges % 2 == 1) ^ scph) begin
                srx = {srx[6:0], mosi};
            end else if (sidx >= 0) begin
                miso_slv = cur_w[sidx];
                sidx--;
            end
        end
        if (!sel && sel_prev && mo_q.size() > 0) begin
            mexp = mo_q.pop_front();
            chk("slave_mosi_word", {24'd0, srx}, {24'd0, mexp});
            chk("slave_sclk_edges", sedges, 16);
        end
        sel_prev  = sel;
        sclk_prev = sclk;
    end

    task automatic wait_idle(input string nm);
        int n = 0;
        while (!tx_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!tx_ready) chk(nm, {31'd0, tx_ready}, 1);
    endtask

    task automatic start(input logic [7:0] d, input logic [1:0] ss, input logic p, input logic h,
                         input logic [7:0] sw, input logic [3:0] ssn_exp);
        @(negedge clk);
        wait_idle("start_ready_timeout");
        mode_cpha = h;
        sw_q.push_back(sw);
        tx_data = d; tx_ss = ss; cpol = p; cpha = h; tx_valid = 1'b1;
        exp_q.push_back(exp_rx(d, sw));
        acc_q.push_back(cyc);
        mo_q.push_back(d);
        @(negedge clk);
        tx_valid = 1'b0;
        tx_data = ~d; tx_ss = ss + 2'd1; cpol = ~p; cpha = ~h;
        chk("ss_n_asserted", {28'd0, ss_n}, {28'd0, ssn_exp});
        chk("sclk_at_setup", {31'd0, sclk}, {31'd0, p});
        chk("tx_ready_busy", {31'd0, tx_ready}, 0);
        if (!h) chk("mosi_msb_setup", {31'd0, mosi}, {31'd0, d[7]});
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        int         n, busy_rdy, edges;
        logic       sp;
        logic [7:0] mt[4];
        mt[0] = 8'h69; mt[1] = 8'h1E; mt[2] = 8'hB4; mt[3] = 8'h7D;

        rst = 1'b1; tx_valid = 1'b0; tx_data = 8'h00; tx_ss = 2'd0; cpol = 1'b0; cpha = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_tx_ready", {31'd0, tx_ready}, 1);
        chk("reset_ss_n", {28'd0, ss_n}, 32'hF);
        chk("reset_sclk", {31'd0, sclk}, 0);
        chk("reset_rx_valid", {31'd0, rx_valid}, 0);
        chk("reset_rx_data", {24'd0, rx_data}, 0);
        chk("reset_mosi", {31'd0, mosi}, 0);

        // Mode 0, slave 2.
        start(8'hA5, 2'd2, 1'b0, 1'b0, 8'h3C, 4'b1011);
        wait_idle("mode0_done_timeout");
        chk("mode0_idle_sclk", {31'd0, sclk}, 0);

        // All four modes.
        for (int m = 0; m < 4; m++) begin
            start(mt[m], 2'(m), m[1], m[0], 8'h96, ~(4'b0001 << m));
            wait_idle("mode_done_timeout");
            chk("idle_sclk_eq_cpol", {31'd0, sclk}, {31'd0, m[1]});
        end

        // Back-to-back with tx_valid held high.
        @(negedge clk);
        wait_idle("b2b_ready_timeout");
        mode_cpha = 1'b0;
        sw_q.push_back(8'hC3);
        sw_q.push_back(8'h18);
        tx_data = 8'h01; tx_ss = 2'd1; cpol = 1'b0; cpha = 1'b0; tx_valid = 1'b1;
        exp_q.push_back(exp_rx(8'h01, 8'hC3));
        acc_q.push_back(cyc);
        mo_q.push_back(8'h01);
        @(negedge clk);
        tx_data = 8'hFF; tx_ss = 2'd3;
        chk("b2b_ss_n_first", {28'd0, ss_n}, 32'hD);
        n = 0; busy_rdy = 0;
        while (!rx_valid && n < 200) begin
            @(negedge clk);
            n++;
            if (tx_ready && !rx_valid) busy_rdy++;
        end
        chk("b2b_rx_valid_seen", {31'd0, rx_valid}, 1);
        chk("b2b_ready_while_busy", busy_rdy, 0);
        chk("b2b_gap_ss_n_high", {28'd0, ss_n}, 32'hF);
        exp_q.push_back(exp_rx(8'hFF, 8'h18));
        acc_q.push_back(cyc);
        mo_q.push_back(8'hFF);
        @(negedge clk);
        tx_valid = 1'b0;
        chk("b2b_ss_n_second", {28'd0, ss_n}, 32'h7);
        wait_idle("b2b_done_timeout");

        // Reset at SCLK edge 5 of 16 with CPOL=1, so sclk must visibly drop to 0.
        @(negedge clk);
        wait_idle("rst_ready_timeout");
        mode_cpha = 1'b0;
        sw_q.push_back(8'hAA);
        tx_data = 8'h33; tx_ss = 2'd0; cpol = 1'b1; cpha = 1'b0; tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        sp = sclk; edges = 0; n = 0;
        while (edges < 5 && n < 100) begin
            @(negedge clk);
            n++;
            if (sclk != sp) edges++;
            sp = sclk;
        end
        chk("rst_edge5_reached", edges, 5);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_ss_n", {28'd0, ss_n}, 32'hF);
        chk("rst_mid_sclk", {31'd0, sclk}, 0);
        chk("rst_mid_tx_ready", {31'd0, tx_ready}, 1);
        chk("rst_mid_rx_valid", {31'd0, rx_valid}, 0);
        repeat (90) @(negedge clk);

        // Loopback word; with the macro undefined this is a plain transfer returning 8'h00.
        start(8'h5A, 2'd0, 1'b0, 1'b0, 8'h00, 4'b1110);
        wait_idle("loop_done_timeout");

        n = 0;
        while (exp_q.size() > 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("scoreboard_drained", exp_q.size(), 0);
        repeat (5) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/spi_master_multi.md
# spi_master_multi

Parametrised SPI master for the SPI subsystem. It drives one shared SCLK/MOSI/MISO bus and a vector of active-low slave selects, and supports all four CPOL/CPHA modes, chosen per transfer. The SCLK rate is set by a parameter, and transfers use a valid/ready handshake on the request side and a valid pulse on the response side. It replaces the fixed single-slave, single-mode master in multi-slave top levels.

## Interface
- WIDTH, 8: bits per transfer, MSB first; legal range ≥ 2.
- NUM_SLAVES, 4: number of slave-select lines; legal range ≥ 1.
- DIV, 4: SCLK half-period in clk cycles; legal range ≥ 2.
- SSW, $clog2(NUM_SLAVES) (minimum 1): width of tx_ss; derived, not overridden.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- tx_valid  in  1  transfer request.
- tx_ready  out  1  high in IDLE; a transfer is accepted when tx_valid and tx_ready are both high.
- tx_data  in  WIDTH  word to shift out.
- tx_ss  in  SSW  index of the target slave.
- cpol  in  1  SCLK idle level, sampled at accept.
- cpha  in  1  0 = sample on the leading edge, 1 = sample on the trailing edge; sampled at accept.
- rx_valid  out  1  one-cycle pulse when rx_data is updated.
- rx_data  out  WIDTH  word received on MISO; held until the next rx_valid.
- sclk  out  1  serial clock.
- mosi  out  1  serial data out.
- miso  in  1  serial data in.
- ss_n  out  NUM_SLAVES  active-low one-hot slave selects.

## Operation
- Reset values:
  - Internal state: IDLE.
  - tx_ready=1, rx_valid=0, rx_data=0, sclk=0, mosi=0, ss_n all ones.
  - Latched CPOL=0, latched CPHA=0.
- On accept, the block latches tx_data into the shift register and also latches tx_ss, cpol and cpha. Later changes to these inputs do not affect the transfer in progress.
- States: IDLE → SETUP → XFER → HOLD → IDLE.
- IDLE:
  - tx_ready=1.
  - sclk holds the latched CPOL.
  - ss_n is all ones.
- SETUP, lasting DIV cycles:
  - ss_n[tx_ss] is driven low. If tx_ss ≥ NUM_SLAVES, no select is asserted but the transfer still runs.
  - If CPHA=0, mosi is driven with the MSB.
- XFER: 2·WIDTH SCLK edges, one edge every DIV cycles. Odd edges are leading edges; even edges are trailing edges.
  - CPHA=0: sample miso on each leading edge; shift out the next bit on each trailing edge except the last.
  - CPHA=1: shift out the next bit on each leading edge (the first leading edge drives the MSB); sample miso on each trailing edge.
  - Sampled bits shift in at the LSB of the receive register.
- HOLD, lasting DIV cycles:
  - sclk is at the CPOL level.
  - ss_n stays asserted.
- On leaving HOLD, in a single cycle:
  - ss_n deasserts.
  - rx_data loads the received word.
  - rx_valid pulses.
  - The state returns to IDLE with tx_ready=1.
- A new accept is possible in the cycle ss_n goes high. Because ss_n changes one cycle after accept, ss_n stays high for at least one full cycle between transfers.
- tx_valid outside IDLE is ignored; there is no queueing.
- rst asserted in any state takes effect on the next edge: all outputs return to their reset values and any partial transfer is discarded without an rx_valid pulse.

## Timing
- Let accept occur at cycle T.
  - ss_n asserts at T+1.
  - SCLK edge k (k = 1..2·WIDTH) occurs at T+1+k·DIV.
  - ss_n deasserts and rx_valid=1 at T+1+(2·WIDTH+1)·DIV.
- Total transfer latency from accept to rx_valid is 1+(2·WIDTH+1)·DIV cycles. For the defaults this is 69 cycles.
- sclk, mosi and ss_n are registered outputs with no combinational path from inputs.
- miso is sampled in the same clk cycle that the register drives the sampling edge, i.e. it is the value present before that edge is visible at the pin.

## Configuration
- SPI_MASTER_LOOPBACK_EN:
  - Defined: the receive path samples the internal mosi register instead of the miso port, so rx_data equals the transmitted word. The miso port is left unconnected internally. Used for bring-up self-test.
  - Undefined: the receive path samples miso. This is normal operation.

## Test plan
- Reset check: assert rst for 3 cycles, then release → tx_ready=1, ss_n=4'b1111, sclk=0, rx_valid=0.
- Mode 0, defaults: tx_data=8'hA5, tx_ss=2, slave model returns 8'h3C →
  - ss_n=4'b1011 from T+1;
  - 8 rising sclk edges, with mosi bits 1,0,1,0,0,1,0,1;
  - rx_data=8'h3C with rx_valid at T+69.
- All four modes: cpol and cpha swept over 00, 01, 10, 11, slave returns 8'h96 →
  - idle sclk equals cpol;
  - rx_data=8'h96 in every mode;
  - mosi is stable at each sampling edge.
- Back-to-back: tx_valid held high with two words, 8'h01 then 8'hFF → second accept in the cycle rx_valid pulses; ss_n high for exactly 1 cycle between transfers; tx_valid ignored while busy.
- Reset mid-transfer: assert rst at edge 5 of 16 → next cycle ss_n all ones, sclk=0, and no rx_valid.
- Loopback: with SPI_MASTER_LOOPBACK_EN defined, miso tied to 0, tx_data=8'h5A → rx_data=8'h5A.
